// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Fetch stage feeding the instruction decoder. Owns the PC, issues one
//   instruction-memory read at a time, latches the returned word in IR and
//   offers it (with its PC and decoded opcode/funct3/funct7 fields) to decode
//   over a valid/ready handshake. Later stages may redirect the PC at any time;
//   a read already in flight when a redirect arrives is drained and dropped.
//
// Build option:
//   IFETCH_ILLEGAL_TRAP_EN - when defined, a fetched word whose opcode is not
//   R-type (0110011), I-type ALU (0010011) or LUI (0110111) parks the stage in
//   HALT with illegal=1 until a redirect or reset. When undefined, every word
//   is forwarded and illegal is tied low.
//
// Ports:
//   clk            in   1   clock, all state on rising edge
//   rst_n          in   1   synchronous active-low reset
//   imem_req       out  1   one-cycle read request
//   imem_addr      out  32  read address (word aligned)
//   imem_rvalid    in   1   read data valid pulse
//   imem_rdata     in   32  instruction word
//   if_valid       out  1   IR holds an instruction for decode
//   id_ready       in   1   decode accepts IR this cycle
//   if_inst        out  32  IR
//   if_pc          out  32  PC of the instruction in IR
//   opcode         out  7   if_inst[6:0]
//   funct3         out  3   if_inst[14:12]
//   funct7         out  7   if_inst[31:25]
//   redirect_valid in   1   load redirect_pc as next fetch address
//   redirect_pc    in   32  new PC, low two bits ignored
//   illegal        out  1   unsupported opcode trapped
//   inst_cnt       out  32  completed handoffs to decode
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        illegal,
    output logic [31:0] inst_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FULL,
        DRAIN,
        HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] if_pc_q;
    logic [31:0] cnt_q;

    logic [31:0] redir_pc_d;
    logic [31:0] pc_inc_d;
    logic [31:0] cnt_inc_d;
    logic        op_legal_d;

    // Masking (rather than slicing) keeps every redirect_pc bit consumed.
    assign redir_pc_d = redirect_pc & ~32'd3;
    assign pc_inc_d   = pc_q + PC_STEP;
    assign cnt_inc_d  = cnt_q + 32'd1;

`ifdef IFETCH_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_comb begin
        op_legal_d = 1'b0;
        case (imem_rdata[6:0])
            7'b0110011: op_legal_d = 1'b1;
            7'b0010011: op_legal_d = 1'b1;
            7'b0110111: op_legal_d = 1'b1;
            default:    op_legal_d = 1'b0;
        endcase
    end

    assign illegal = illegal_q;
`else
    assign op_legal_d = 1'b1;
    assign illegal    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= NOP;
            if_pc_q   <= RESET_PC;
            cnt_q     <= '0;
`ifdef IFETCH_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc_d;
                    end
                    state_q <= REQ;
                end

                // The request in this state has already gone out, so a
                // redirect here still leaves one response to drain.
                REQ: begin
                    if (redirect_valid) begin
                        pc_q    <= redir_pc_d;
                        state_q <= DRAIN;
                    end else begin
                        state_q <= WAIT;
                    end
                end

                WAIT: begin
                    if (redirect_valid) begin
                        pc_q    <= redir_pc_d;
                        // Response arriving with the redirect is consumed and
                        // dropped; otherwise it is still outstanding.
                        state_q <= imem_rvalid ? REQ : DRAIN;
                    end else if (imem_rvalid) begin
                        ir_q    <= imem_rdata;
                        if_pc_q <= pc_q;
                        if (op_legal_d) begin
                            pc_q    <= pc_inc_d;
                            state_q <= FULL;
                        end else begin
                            state_q <= HALT;
`ifdef IFETCH_ILLEGAL_TRAP_EN
                            illegal_q <= 1'b1;
`endif
                        end
                    end
                end

                FULL: begin
                    if (redirect_valid) begin
                        pc_q    <= redir_pc_d;
                        state_q <= REQ;
                    end else if (id_ready) begin
                        cnt_q   <= cnt_inc_d;
                        state_q <= REQ;
                    end
                end

                DRAIN: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc_d;
                    end
                    if (imem_rvalid) begin
                        state_q <= REQ;
                    end
                end

                HALT: begin
                    if (redirect_valid) begin
                        pc_q    <= redir_pc_d;
                        state_q <= REQ;
`ifdef IFETCH_ILLEGAL_TRAP_EN
                        illegal_q <= 1'b0;
`endif
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;
    assign if_valid  = (state_q == FULL);
    assign if_inst   = ir_q;
    assign if_pc     = if_pc_q;
    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[31:25];
    assign inst_cnt  = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Self-checking bench for inst_fetch: a per-cycle vector table for the basic
//   fetch/stall/redirect timeline, hand-written sequences for reset-in-flight,
//   PC wrap and the illegal-opcode trap, then a randomized run against a
//   transaction-level reference model with a variable-latency memory.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        illegal;
    logic [31:0] inst_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    inst_fetch #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .id_ready      (id_ready),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .illegal       (illegal),
        .inst_cnt      (inst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, e, $time);
        end
    endtask

    // Apply inputs for one cycle, then sample just after the rising edge.
    task automatic drive(input logic r, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rdv, input logic [31:0] rpc);
        rst_n          = r;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        id_ready       = rdy;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_ctl(input string nm, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_cnt);
        chk({nm, "_req"}, imem_req, e_req);
        chk({nm, "_addr"}, imem_addr, e_addr);
        chk({nm, "_valid"}, if_valid, e_valid);
        chk({nm, "_cnt"}, inst_cnt, e_cnt);
    endtask

    task automatic chk_ir(input string nm, input logic [31:0] e_inst, input logic [31:0] e_pc);
        logic [31:0] w;
        w = e_inst;
        chk({nm, "_inst"}, if_inst, w);
        chk({nm, "_pc"}, if_pc, e_pc);
        chk({nm, "_opcode"}, opcode, w[6:0]);
        chk({nm, "_funct3"}, funct3, w[14:12]);
        chk({nm, "_funct7"}, funct7, w[31:25]);
    endtask

    // Deterministic memory image; only supported opcodes so the random run
    // is valid whether or not the trap is built in.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        case (a[3:2])
            2'd0:    op = 7'b0110011;
            2'd1:    op = 7'b0010011;
            2'd2:    op = 7'b0110111;
            default: op = 7'b0010011;
        endcase
        return {a[28:4] ^ 25'h15A_5A5A, op};
    endfunction

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        rdv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        e_chk;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[24];

    task automatic row(input int i, input logic r, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdv, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic e_chk, input logic [31:0] e_inst, input logic [31:0] e_pc,
                       input logic [31:0] e_cnt);
        tbl[i] = '{r, rv, rd, rdy, rdv, rpc, e_req, e_addr, e_valid, e_chk, e_inst, e_pc, e_cnt};
    endtask

    initial begin
        logic [31:0] m_addr, m_ir, m_pc, m_cnt, o_addr, mem_addr, rd, rpc;
        logic        live, outst, taint, rv, rdy, rdv;
        int unsigned mem_cnt;

        //   i  rst rv rdata         rdy rdv rpc          req addr         vld chk inst          pc           cnt
        row(0,  0, 0, 32'h0,        0,  0,  32'h0,       0,  32'h0,       0,  1,  32'h0000_0013, 32'h0,     0);
        row(1,  1, 0, 32'h0,        0,  0,  32'h0,       1,  32'h0,       0,  1,  32'h0000_0013, 32'h0,     0);
        row(2,  1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h0,       0,  1,  32'h0000_0013, 32'h0,     0);
        row(3,  1, 1, 32'h0050_0093, 0, 0,  32'h0,       0,  32'h4,       1,  1,  32'h0050_0093, 32'h0,     0);
        row(4,  1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h4,       1,  1,  32'h0050_0093, 32'h0,     0);
        row(5,  1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h4,       1,  1,  32'h0050_0093, 32'h0,     0);
        row(6,  1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h4,       1,  1,  32'h0050_0093, 32'h0,     0);
        row(7,  1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h4,       1,  1,  32'h0050_0093, 32'h0,     0);
        row(8,  1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h4,       1,  1,  32'h0050_0093, 32'h0,     0);
        row(9,  1, 0, 32'h0,        1,  0,  32'h0,       1,  32'h4,       0,  0,  32'h0,         32'h0,     1);
        row(10, 1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h4,       0,  0,  32'h0,         32'h0,     1);
        row(11, 1, 0, 32'h0,        0,  1,  32'h103,     0,  32'h100,     0,  0,  32'h0,         32'h0,     1);
        row(12, 1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h100,     0,  0,  32'h0,         32'h0,     1);
        row(13, 1, 1, 32'h00A0_0113, 0, 0,  32'h0,       1,  32'h100,     0,  1,  32'h0050_0093, 32'h0,     1);
        row(14, 1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h100,     0,  0,  32'h0,         32'h0,     1);
        row(15, 1, 1, 32'h0020_81B3, 0, 0,  32'h0,       0,  32'h104,     1,  1,  32'h0020_81B3, 32'h100,   1);
        row(16, 1, 0, 32'h0,        1,  1,  32'h200,     1,  32'h200,     0,  0,  32'h0,         32'h0,     1);
        row(17, 1, 0, 32'h0,        0,  1,  32'h300,     0,  32'h300,     0,  0,  32'h0,         32'h0,     1);
        row(18, 1, 1, 32'hDEAD_BEEF, 0, 0,  32'h0,       1,  32'h300,     0,  0,  32'h0,         32'h0,     1);
        row(19, 1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h300,     0,  0,  32'h0,         32'h0,     1);
        row(20, 1, 1, 32'h1111_1113, 0, 1,  32'h400,     1,  32'h400,     0,  0,  32'h0,         32'h0,     1);
        row(21, 1, 0, 32'h0,        0,  0,  32'h0,       0,  32'h400,     0,  0,  32'h0,         32'h0,     1);
        row(22, 1, 1, 32'h0000_02B7, 0, 0,  32'h0,       0,  32'h404,     1,  1,  32'h0000_02B7, 32'h400,   1);
        row(23, 1, 0, 32'h0,        1,  0,  32'h0,       1,  32'h404,     0,  0,  32'h0,         32'h0,     2);

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rst_n, tbl[i].rv, tbl[i].rd, tbl[i].rdy, tbl[i].rdv, tbl[i].rpc);
            chk_ctl($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_cnt);
            chk($sformatf("vec%0d_illegal", i), illegal, 1'b0);
            if (tbl[i].e_chk)
                chk_ir($sformatf("vec%0d", i), tbl[i].e_inst, tbl[i].e_pc);
        end

        // Reset during WAIT with a response in the same cycle.
        idle_cycle();                                            // REQ -> WAIT
        drive(1'b0, 1'b1, 32'h1234_5013, 1'b0, 1'b0, '0);
        chk_ctl("rstwait", 1'b0, 32'h0, 1'b0, 32'd0);
        chk("rstwait_inst", if_inst, 32'h0000_0013);
        chk("rstwait_pc", if_pc, 32'h0);
        drive(1'b1, 1'b1, 32'h0000_0033, 1'b0, 1'b0, '0);        // rvalid in IDLE ignored
        chk_ctl("rstidle", 1'b1, 32'h0, 1'b0, 32'd0);
        chk("rstidle_inst", if_inst, 32'h0000_0013);
        idle_cycle();
        drive(1'b1, 1'b1, 32'h0010_0093, 1'b0, 1'b0, '0);
        chk_ctl("rstfetch", 1'b0, 32'h4, 1'b1, 32'd0);
        chk_ir("rstfetch", 32'h0010_0093, 32'h0);
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        chk_ctl("rstaccept", 1'b1, 32'h4, 1'b0, 32'd1);

        // PC wrap; the unaligned redirect bits must be dropped.
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk_ctl("wrapreq", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        idle_cycle();
        drive(1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, '0);
        chk_ctl("wrapfull", 1'b0, 32'h0, 1'b1, 32'd0);
        chk_ir("wrapfull", 32'h0000_0013, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        chk_ctl("wrapnext", 1'b1, 32'h0, 1'b0, 32'd1);

        // Branch opcode: trapped when the option is built, forwarded otherwise.
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        idle_cycle();
        idle_cycle();
        drive(1'b1, 1'b1, 32'h0000_0063, 1'b0, 1'b0, '0);
`ifdef IFETCH_ILLEGAL_TRAP_EN
        chk_ctl("trap", 1'b0, 32'h0, 1'b0, 32'd0);
        chk("trap_illegal", illegal, 1'b1);
        chk("trap_inst", if_inst, 32'h0000_0063);
        chk("trap_pc", if_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
            chk_ctl($sformatf("halt%0d", i), 1'b0, 32'h0, 1'b0, 32'd0);
            chk($sformatf("halt%0d_illegal", i), illegal, 1'b1);
        end
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h40);
        chk_ctl("trapexit", 1'b1, 32'h40, 1'b0, 32'd0);
        chk("trapexit_illegal", illegal, 1'b0);
`else
        chk_ctl("notrap", 1'b0, 32'h4, 1'b1, 32'd0);
        chk("notrap_illegal", illegal, 1'b0);
        chk_ir("notrap", 32'h0000_0063, 32'h0);
`endif

        // Randomized run. Model: the next request address is the last redirect
        // target, else the word after the last delivered one; a response is
        // presented only if no redirect touched its request; handoffs count.
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        m_addr = 32'h0; m_cnt = '0; m_ir = '0; m_pc = '0; o_addr = '0;
        live = 1'b0; outst = 1'b0; taint = 1'b0;
        mem_cnt = 0; mem_addr = '0;
        for (int c = 0; c < 4000; c++) begin
            chk("rnd_valid", if_valid, live);
            chk("rnd_cnt", inst_cnt, m_cnt);
            if (live) begin
                chk("rnd_inst", if_inst, m_ir);
                chk("rnd_pc", if_pc, m_pc);
            end
            if (imem_req) begin
                chk("rnd_addr", imem_addr, m_addr);
                chk("rnd_one_outstanding", outst, 1'b0);
            end

            rv = 1'b0;
            rd = $urandom;
            if (mem_cnt != 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    rv = 1'b1;
                    rd = mem_word(mem_addr);
                end
            end
            if (imem_req) begin
                mem_addr = imem_addr;
                mem_cnt  = $urandom_range(1, 3);
            end
            rdy = 1'($urandom_range(0, 1));
            rdv = ($urandom_range(0, 19) == 0);
            rpc = $urandom;

            if (imem_req) begin
                outst  = 1'b1;
                o_addr = m_addr;
                taint  = rdv;
            end
            if (rdv) begin
                m_addr = rpc & ~32'd3;
                live   = 1'b0;
            end else if (live && rdy) begin
                live  = 1'b0;
                m_cnt = m_cnt + 32'd1;
            end
            if (rv) begin
                outst = 1'b0;
                if (!taint && !rdv) begin
                    live   = 1'b1;
                    m_ir   = mem_word(o_addr);
                    m_pc   = o_addr;
                    m_addr = o_addr + 32'd4;
                end
            end else if (rdv && outst) begin
                taint = 1'b1;
            end

            drive(1'b1, rv, rd, rdy, rdv, rpc);
        end
        chk("rnd_progress", (inst_cnt >= 32'd100), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
